// File: rtl/serial_number_loader.sv
// Assembles a framed, MSB-first serial bit stream into a WIDTH-bit word.
// Reports completed words with a valid pulse and aborted or stalled frames with an error pulse.
module serial_number_loader #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inStart,
   input  logic             inBit,
   input  logic             inBitValid,
   output logic [WIDTH-1:0] outNumber,
   output logic             outValid,
   output logic             outBusy,
   output logic             outError
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [WIDTH-1:0]   shift_r;
   logic [WIDTH-1:0]   shift_s;
   logic [WIDTH-1:0]   shifted_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_s;
   logic [TMR_W-1:0]   timer_r;
   logic [TMR_W-1:0]   timer_s;
   logic [WIDTH-1:0]   number_s;
   logic               valid_s;
   logic               error_s;
   logic               busy_r;

   // Shift register contents if the current bit is accepted.
   always_comb begin
      shifted_s = {shift_r[WIDTH-2:0], inBit};
   end

   // Next-state and next-output logic; start beats bit beats timeout.
   always_comb begin
      next_state_s = state_r;
      shift_s      = shift_r;
      cnt_s        = cnt_r;
      timer_s      = timer_r;
      number_s     = outNumber;
      valid_s      = 1'b0;
      error_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (inStart) begin
               next_state_s = SHIFT;
               shift_s      = {WIDTH{1'b0}};
               cnt_s        = {CNT_W{1'b0}};
               timer_s      = {TMR_W{1'b0}};
            end else begin
               next_state_s = IDLE;
            end
         end
         SHIFT: begin
            if (inStart) begin
               // Restart in place: the partial frame is dropped, any coincident bit too.
               error_s = 1'b1;
               shift_s = {WIDTH{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
               timer_s = {TMR_W{1'b0}};
            end else if (inBitValid) begin
               shift_s = shifted_s;
               timer_s = {TMR_W{1'b0}};
               if (cnt_r == CNT_LAST) begin
                  number_s     = shifted_s;
                  valid_s      = 1'b1;
                  cnt_s        = {CNT_W{1'b0}};
                  next_state_s = IDLE;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               if (timer_r == TMR_LAST) begin
                  error_s      = 1'b1;
                  timer_s      = {TMR_W{1'b0}};
                  next_state_s = IDLE;
               end else begin
                  timer_s = timer_r + TMR_ONE;
               end
            end
         end
         default: begin
            next_state_s = IDLE;
            shift_s      = {WIDTH{1'b0}};
            cnt_s        = {CNT_W{1'b0}};
            timer_s      = {TMR_W{1'b0}};
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         shift_r   <= {WIDTH{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         timer_r   <= {TMR_W{1'b0}};
         outNumber <= {WIDTH{1'b0}};
         outValid  <= 1'b0;
         outError  <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         shift_r   <= shift_s;
         cnt_r     <= cnt_s;
         timer_r   <= timer_s;
         outNumber <= number_s;
         outValid  <= valid_s;
         outError  <= error_s;
         busy_r    <= (next_state_s == SHIFT);
      end
   end

   assign outBusy = busy_r;

endmodule

// File: doc/serial_number_loader.md
# serial_number_loader

Upstream feeder for the divisible-by-3 checker. It receives a number as a framed, MSB-first serial bit stream and assembles it into a WIDTH-bit word. It presents the word on a held parallel output with a one-cycle valid pulse, which the checker consumes directly. It also detects aborted and stalled frames.

## Interface
- WIDTH, 8: bits per frame and width of outNumber; must be ≥ 2.
- TIMEOUT, 16: consecutive bit-less cycles in SHIFT that abort a frame; must be ≥ 1.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- inStart  input  1  frame start strobe, sampled each edge.
- inBit  input  1  serial data bit, meaningful only when inBitValid=1.
- inBitValid  input  1  inBit is valid this cycle.
- outNumber  output  WIDTH  last completed word; held until the next completion.
- outValid  output  1  one-cycle pulse; outNumber was updated this cycle.
- outBusy  output  1  frame in progress (state SHIFT).
- outError  output  1  one-cycle pulse; a frame was aborted.

## Operation
- **States:** IDLE, SHIFT. Internal registers:
  - shift register, WIDTH bits;
  - bit counter, clog2(WIDTH) bits;
  - idle timer, clog2(TIMEOUT+1) bits.
- **IDLE:**
  - inStart=1 → SHIFT; clear the bit counter, shift register and timer.
  - inBitValid is ignored in IDLE, including in the cycle where inStart is asserted.
- **SHIFT, inStart=1:** highest priority.
  - The frame is aborted and outError pulses.
  - The block stays in SHIFT and restarts: counter, shift register and timer are cleared.
  - A coincident inBitValid is discarded.
- **SHIFT, inBitValid=1 (no inStart):**
  - shift ← {shift[WIDTH-2:0], inBit}, so the first bit received ends up as the MSB.
  - The counter increments and the timer clears.
  - If the counter was WIDTH-1: outNumber ← {shift[WIDTH-2:0], inBit}, outValid pulses, and the next state is IDLE.
- **SHIFT, no inBitValid, no inStart:**
  - The timer increments.
  - If the timer was TIMEOUT-1: outError pulses, the next state is IDLE, and outNumber is unchanged.
- **Priority:** start > bit > timeout. A bit arriving in the cycle the timer would expire is accepted, and no error is raised.
- **Aborted frames** never modify outNumber and never raise outValid.
- outValid and outError are never asserted in the same cycle.
- **Arithmetic:**
  - All counters are unsigned.
  - The bit counter never exceeds WIDTH-1.
  - The timer never exceeds TIMEOUT-1; it saturates by exiting SHIFT.
  - No wrap-around is reachable.

## Timing
- **Reset values** (rst=1, asynchronously): state IDLE; outNumber=0, outValid=0, outError=0, outBusy=0; counters and shift register 0.
- All outputs are registered; no combinational path from inputs to outputs.
- **outBusy:** high from the cycle after the edge that samples inStart until the cycle after the edge that samples the final bit or the timeout.
- **Latency:** outValid and the new outNumber appear together, one cycle after the edge that samples the final bit.
- **Throughput:**
  - inStart may be asserted in the same cycle outValid is high; it is accepted.
  - Minimum frame period is WIDTH+1 cycles (start + WIDTH bits).
- **outError:** high for exactly one cycle, one cycle after the aborting edge.
- **Timeout:** with inBitValid low for TIMEOUT consecutive cycles in SHIFT, outError rises TIMEOUT cycles after the last accepted bit's edge (or after the start edge if no bit was accepted).
- **Reset mid-frame:** the partial frame is discarded and outNumber returns to 0. No outValid or outError pulse is generated by reset.

## Test plan
- **Back-to-back frames:** inStart, then bits 1,0,0,1,0,0,1,1 on consecutive cycles → outNumber=8'h93 (147), outValid high 1 cycle, exactly 9 cycles after start. Second frame started in the outValid cycle with bits 0,0,0,0,0,1,1,1 → outNumber=8'h07.
- **Gapped bits:** frame 8'h93 with 3 idle cycles between every bit (gap < TIMEOUT) → outNumber=8'h93, outValid once, outError never.
- **Mid-frame abort:** inStart, 4 bits, then inStart together with inBitValid → outError 1 cycle, outBusy stays 1, that bit is discarded. Then 8 bits of 8'hFF → outNumber=8'hFF. Previously held outNumber is untouched until then.
- **Timeout boundary:**
  - inStart, 2 bits, then 15 idle cycles, then a bit → accepted, no error.
  - Repeat with 16 idle cycles → outError pulse, outBusy=0, outNumber unchanged.
- **Reset mid-frame:** after outNumber=8'h93, start a frame, send 5 bits, assert rst for 1 cycle → outputs immediately 0. A following 8'h03 frame completes normally → outNumber=8'h03.
- **Ignored input in IDLE:** inBitValid pulses while in IDLE, no start → no state change, outBusy=0, no outValid.
